// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, performs one handshaked word read per
// instruction and holds the result until the decode stage completes it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    input  logic        instr_ready,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] target;
    logic        target_ok;

    // Code 11 is unused by the control unit and falls back to sequential.
    function automatic logic [31:0] next_pc(input logic [1:0]  src,
                                            input logic [31:0] cur,
                                            input logic [31:0] imm,
                                            input logic [31:0] alu);
        case (src)
            2'b01:   next_pc = cur + imm;
            2'b10:   next_pc = alu & ~32'h1;
            default: next_pc = cur + 32'd4;
        endcase
    endfunction

    assign target    = next_pc(pc_src, pc_q, imm_ext, alu_result);
    assign target_ok = (target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            pc_q  <= RESET_PC;
        end else begin
            case (state)
                S_REQ:   if (imem_req_ready) state <= S_WAIT;
                S_WAIT:  if (imem_resp_valid) state <= S_HOLD;
                S_HOLD: begin
                    if (instr_ready) begin
                        if (target_ok) begin
                            pc_q  <= target;
                            state <= S_REQ;
                        end else begin
                            state <= S_FAULT;
                        end
                    end
                end
                default: state <= S_FAULT;
            endcase
        end
    end

    // Data register is not reset: the output mux hides it unless HOLD.
    always_ff @(posedge clk) begin
        if (state == S_WAIT && imem_resp_valid)
            instr_q <= imem_resp_data;
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state == S_HOLD);
    assign instr          = instr_valid ? instr_q : NOP_INSTR;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign fetch_fault    = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm_ext = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic        instr_ready = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    logic        mem_rv = 1'b0;
    logic [31:0] mem_rd = 32'h0;
    logic        spur_v = 1'b0;
    logic [31:0] spur_d = 32'h0;
    int          lat = 1;

    int n_tests = 0;
    int n_fail  = 0;

    assign imem_resp_valid = mem_rv | spur_v;
    assign imem_resp_data  = spur_v ? spur_d : mem_rd;

    fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .imm_ext(imm_ext),
        .alu_result(alu_result), .instr_ready(instr_ready),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory: word at address a reads as a ^ A5A5_0000, delivered lat cycles after acceptance.
    logic        m_acc, m_rst, pend = 1'b0;
    logic [31:0] m_addr, paddr;
    int          cnt = 0;
    always @(posedge clk) begin
        m_acc  = imem_req_valid && imem_req_ready;
        m_rst  = rst;
        m_addr = imem_addr;
        #1;
        mem_rv = 1'b0;
        if (m_rst) begin
            pend = 1'b0;
        end else begin
            if (m_acc) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = m_addr;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mem_rv = 1'b1;
                    mem_rd = paddr ^ 32'hA5A5_0000;
                    pend   = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // From REQ at epc through WAIT into HOLD, checking each phase.
    task automatic to_hold(input logic [31:0] epc);
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_addr, epc);
        check("req_instr_nop", instr, 32'h0000_0013);
        tick();
        check("wait_req_valid", 32'(imem_req_valid), 32'd0);
        check("wait_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_instr", instr, epc ^ 32'hA5A5_0000);
        check("hold_pc", pc, epc);
        check("hold_pc_plus4", pc_plus4, epc + 32'd4);
    endtask

    task automatic fetch(input logic [31:0] epc, input logic [1:0] src,
                         input logic [31:0] imm, input logic [31:0] alu,
                         input logic [31:0] enext);
        to_hold(epc);
        pc_src = src;
        imm_ext = imm;
        alu_result = alu;
        tick();
        check("next_addr", imem_addr, enext);
        check("next_instr_valid", 32'(instr_valid), 32'd0);
        // Junk outside the accept cycle must be ignored.
        pc_src = 2'b10;
        alu_result = 32'h0000_0777;
        imm_ext = 32'h0000_0555;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_pc", pc, 32'h0000_0100);
        check("rst_addr", imem_addr, 32'h0000_0100);
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        rst = 1'b0;

        fetch(32'h0000_0100, 2'b00, 32'h0, 32'h0, 32'h0000_0104);
        fetch(32'h0000_0104, 2'b00, 32'h0, 32'h0, 32'h0000_0108);
        fetch(32'h0000_0108, 2'b00, 32'h0, 32'h0, 32'h0000_010C);
        fetch(32'h0000_010C, 2'b01, 32'h0000_00F4, 32'h0, 32'h0000_0200);
        fetch(32'h0000_0200, 2'b01, 32'hFFFF_FFF0, 32'h0, 32'h0000_01F0);
        fetch(32'h0000_01F0, 2'b11, 32'h0000_0040, 32'h0, 32'h0000_01F4);
        fetch(32'h0000_01F4, 2'b10, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 2'b00, 32'h0, 32'h0, 32'h0000_0000);
        fetch(32'h0000_0000, 2'b10, 32'h0, 32'h0000_3001, 32'h0000_3000);

        // Backpressure on request, slow response, long hold with a stray response.
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        lat = 4;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check("stall_addr", imem_addr, 32'h0000_3000);
        end
        imem_req_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("slow_wait_req", 32'(imem_req_valid), 32'd0);
            check("slow_wait_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            check("stall_hold_valid", 32'(instr_valid), 32'd1);
            check("stall_hold_instr", instr, 32'hA5A5_3000);
            check("stall_hold_pc", pc, 32'h0000_3000);
            check("stall_hold_req", 32'(imem_req_valid), 32'd0);
            spur_v = (i == 2);
            spur_d = 32'hDEAD_BEEF;
            tick();
        end
        spur_v = 1'b0;
        check("spurious_instr", instr, 32'hA5A5_3000);
        lat = 1;
        pc_src = 2'b00;
        instr_ready = 1'b1;
        tick();
        check("after_stall_addr", imem_addr, 32'h0000_3004);

        // jalr with alu_result[1] set faults.
        to_hold(32'h0000_3004);
        pc_src = 2'b10;
        alu_result = 32'h0000_3002;
        tick();
        check("fault_set", 32'(fetch_fault), 32'd1);
        check("fault_pc", pc, 32'h0000_3004);
        check("fault_instr_valid", 32'(instr_valid), 32'd0);
        check("fault_instr", instr, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            spur_v = 1'b1;
            spur_d = 32'h0000_1234;
            tick();
            check("fault_no_req", 32'(imem_req_valid), 32'd0);
            check("fault_sticky", 32'(fetch_fault), 32'd1);
            check("fault_pc_hold", pc, 32'h0000_3004);
        end
        spur_v = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fault_clr", 32'(fetch_fault), 32'd0);
        check("fault_clr_pc", pc, 32'h0000_0100);
        check("fault_clr_req", 32'(imem_req_valid), 32'd1);

        // Misaligned branch target also faults, pc unchanged.
        to_hold(32'h0000_0100);
        pc_src = 2'b01;
        imm_ext = 32'h0000_0002;
        tick();
        check("br_fault", 32'(fetch_fault), 32'd1);
        check("br_fault_pc", pc, 32'h0000_0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("br_fault_clr", 32'(fetch_fault), 32'd0);

        // Reset during WAIT aborts the outstanding fetch.
        pc_src = 2'b00;
        tick();
        check("abort_in_wait", 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        tick();
        check("abort_pc", pc, 32'h0000_0100);
        check("abort_valid", 32'(instr_valid), 32'd0);
        check("abort_instr", instr, 32'h0000_0013);
        check("abort_req", 32'(imem_req_valid), 32'd1);
        tick();
        check("rst_held_req", 32'(imem_req_valid), 32'd1);
        check("rst_held_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        fetch(32'h0000_0100, 2'b00, 32'h0, 32'h0, 32'h0000_0104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding the control and datapath decode of the RISC-V core. Holds the program counter, issues one word read per instruction to instruction memory over a valid/ready request plus valid response, and presents the fetched instruction until the downstream stage accepts it. On acceptance it selects the next PC from the 2-bit PC-source code produced by the control unit (sequential, branch/jal target, jalr target). Misaligned targets raise a sticky fault and halt fetching.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is held (addi x0,x0,0)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_src  in  2  next-PC select from control unit, sampled only on the accept cycle: 00 PC+4, 01 PC+imm_ext, 10 alu_result with bit0 cleared, 11 treated as 00
- imm_ext  in  32  sign-extended immediate for the held instruction
- alu_result  in  32  ALU output for the held instruction (jalr target)
- instr_ready  in  1  downstream has completed the held instruction this cycle
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  read address, equals pc
- imem_resp_valid  in  1  read data valid
- imem_resp_data  in  32  read data
- instr  out  32  held instruction, NOP_INSTR when instr_valid=0
- instr_valid  out  1  instr/pc/pc_plus4 are valid
- pc  out  32  address of the held/pending instruction
- pc_plus4  out  32  pc + 4, for jal/jalr link writeback
- fetch_fault  out  1  sticky misaligned-target fault

## Operation
- States: REQ, WAIT, HOLD, FAULT.
- REQ: imem_req_valid=1, imem_addr=pc. Handshake when imem_req_valid & imem_req_ready -> WAIT. Stay in REQ holding address stable otherwise.
- WAIT: imem_req_valid=0. On imem_resp_valid capture imem_resp_data into instr register -> HOLD. Responses arriving in REQ, HOLD or FAULT are ignored.
- HOLD: instr_valid=1, instr/pc stable. On instr_ready: compute target per pc_src (32-bit, mod 2^32 wrap, no overflow detection). If target[1:0]==00: pc<=target -> REQ. Else: pc unchanged -> FAULT.
- FAULT: instr_valid=0, imem_req_valid=0, fetch_fault=1; leaves only on rst.
- jalr target: alu_result & ~32'h1 before alignment check; so alu_result[1]=1 faults, alu_result[0]=1 alone does not.
- pc_plus4 = pc + 4 combinationally, wrapping 32'hFFFF_FFFC -> 0.
- No speculative or overlapping fetch: at most one request outstanding.

## Timing
- Reset values (cycle after rst sampled high): state=REQ, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, fetch_fault=0, imem_req_valid=1, imem_addr=RESET_PC.
- rst held high: outputs stay at reset values; rst high in any state (including mid-WAIT or HOLD) aborts and restarts at REQ; memory is reset by the same rst, so no stale response is delivered.
- Minimum throughput: 3 cycles/instruction (REQ with ready=1, WAIT with same-next-cycle response, HOLD with instr_ready=1).
- Response latency: memory returns data no earlier than the cycle after request acceptance; any length of stall in REQ/WAIT/HOLD is tolerated.
- instr_valid rises the cycle after imem_resp_valid sampled in WAIT; falls the cycle after instr_ready sampled in HOLD.
- instr_ready outside HOLD has no effect. pc_src, imm_ext, alu_result are don't-care outside the HOLD accept cycle.
- fetch_fault rises the cycle after the faulting accept and stays high until rst.

## Test plan
- Reset with RESET_PC=0x100, imem_req_ready=1, 1-cycle response, instr_ready=1, pc_src=00 -> imem_addr 0x100,0x104,0x108 each 3 cycles apart; instr_valid one cycle per instruction.
- Branch: at pc=0x200 accept with pc_src=01, imm_ext=0xFFFF_FFF0 -> next imem_addr 0x1F0; pc_plus4 was 0x204 while held.
- jalr: pc_src=10, alu_result=0x0000_3001 -> next pc 0x3000; alu_result=0x0000_3002 -> fetch_fault=1, no further imem_req_valid, pc stays.
- Backpressure: imem_req_ready=0 for 5 cycles, response 4 cycles later, instr_ready held 0 for 6 cycles -> imem_addr stable through stall, instr/pc stable in HOLD, no extra request issued.
- Spurious response: imem_resp_valid pulsed in HOLD with 0xDEAD_BEEF -> instr unchanged.
- rst asserted during WAIT -> next cycle pc=RESET_PC, instr_valid=0, instr=0x0000_0013, imem_req_valid=1; fault cleared when rst applied in FAULT.
